// File: rtl/activation_reg_bank.sv
// Bank of CH activation registers with init load, masked ReLU-clamped updates,
// and iteration / stability / nonzero tracking used for loop termination.
module activation_reg_bank #(
    parameter int WIDTH    = 32,
    parameter int CH       = 4,
    parameter int RELU     = 1,
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255,
    parameter int STABLE_N = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ldInit,
    input  logic                      ldA,
    input  logic [CH-1:0]             chEn,
    input  logic [CH*WIDTH-1:0]       initDataIn,
    input  logic [CH*WIDTH-1:0]       newDataIn,
    output logic [CH*WIDTH-1:0]       dataOut,
    output logic [$clog2(CH+1)-1:0]   nonZeroCnt,
    output logic                      winner,
    output logic                      changed,
    output logic                      stable,
    output logic [ITER_W-1:0]         iterCnt,
    output logic                      timeout
);

    localparam int CNT_W = $clog2(CH+1);
    localparam int RUN_W = $clog2(STABLE_N+1);
    localparam logic [ITER_W-1:0] ITER_MAX_V = ITER_W'(MAX_ITER);
    localparam logic [RUN_W-1:0]  RUN_MAX_V  = RUN_W'(STABLE_N);

    logic [CH*WIDTH-1:0] data_q, data_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic                changed_q, changed_d;
    logic [CH*WIDTH-1:0] upd_vec;
    logic [CNT_W-1:0]    nz_cnt;

    // Negative update values become zero when the ReLU clamp is built in.
    function automatic logic [WIDTH-1:0] relu_clamp(input logic [WIDTH-1:0] v);
        if ((RELU != 0) && v[WIDTH-1]) begin
            return '0;
        end
        return v;
    endfunction

    always_comb begin
        upd_vec = '0;
        for (int i = 0; i < CH; i++) begin
            upd_vec[i*WIDTH +: WIDTH] = relu_clamp(newDataIn[i*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        data_d    = data_q;
        iter_d    = iter_q;
        run_d     = run_q;
        changed_d = changed_q;
        if (ldInit) begin
            data_d    = initDataIn;
            iter_d    = '0;
            run_d     = '0;
            changed_d = 1'b0;
        end else if (ldA) begin
            changed_d = 1'b0;
            for (int i = 0; i < CH; i++) begin
                if (chEn[i]) begin
                    if (upd_vec[i*WIDTH +: WIDTH] != data_q[i*WIDTH +: WIDTH]) begin
                        changed_d = 1'b1;
                    end
                    data_d[i*WIDTH +: WIDTH] = upd_vec[i*WIDTH +: WIDTH];
                end
            end
            // Run length saturates at STABLE_N so stable stays up while quiet.
            if (changed_d) begin
                run_d = '0;
            end else if (run_q != RUN_MAX_V) begin
                run_d = run_q + 1'b1;
            end
            if (iter_q != ITER_MAX_V) begin
                iter_d = iter_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            iter_q    <= '0;
            run_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            iter_q    <= iter_d;
            run_q     <= run_d;
            changed_q <= changed_d;
        end
    end

    always_comb begin
        nz_cnt = '0;
        for (int i = 0; i < CH; i++) begin
            nz_cnt = nz_cnt + CNT_W'(|data_q[i*WIDTH +: WIDTH]);
        end
    end

    assign dataOut    = data_q;
    assign nonZeroCnt = nz_cnt;
    assign winner     = (nz_cnt == CNT_W'(1));
    assign changed    = changed_q;
    assign stable     = (run_q == RUN_MAX_V);
    assign iterCnt    = iter_q;
    assign timeout    = (iter_q == ITER_MAX_V);

endmodule

// File: tb/tb_activation_reg_bank.sv
// Scoreboard bench: two configurations (A: RELU=1,MAX_ITER=3,STABLE_N=2;
// B: RELU=0,MAX_ITER=5,STABLE_N=1) driven in parallel against a behavioural model.
module tb_activation_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, ldInit, ldA;
    logic [3:0]   chEn;
    logic [127:0] initDataIn, newDataIn;

    logic [127:0] a_dataOut, b_dataOut;
    logic [2:0]   a_nz, b_nz;
    logic         a_win, b_win, a_chg, b_chg, a_stb, b_stb, a_tmo, b_tmo;
    logic [7:0]   a_iter, b_iter;

    activation_reg_bank #(.WIDTH(32), .CH(4), .RELU(1), .ITER_W(8), .MAX_ITER(3), .STABLE_N(2)) dut_a (
        .clk(clk), .rst(rst), .ldInit(ldInit), .ldA(ldA), .chEn(chEn),
        .initDataIn(initDataIn), .newDataIn(newDataIn), .dataOut(a_dataOut),
        .nonZeroCnt(a_nz), .winner(a_win), .changed(a_chg), .stable(a_stb),
        .iterCnt(a_iter), .timeout(a_tmo));

    activation_reg_bank #(.WIDTH(32), .CH(4), .RELU(0), .ITER_W(8), .MAX_ITER(5), .STABLE_N(1)) dut_b (
        .clk(clk), .rst(rst), .ldInit(ldInit), .ldA(ldA), .chEn(chEn),
        .initDataIn(initDataIn), .newDataIn(newDataIn), .dataOut(b_dataOut),
        .nonZeroCnt(b_nz), .winner(b_win), .changed(b_chg), .stable(b_stb),
        .iterCnt(b_iter), .timeout(b_tmo));

    typedef struct {
        logic [127:0] data;
        int           nz;
        bit           win;
        bit           chg;
        bit           stb;
        int           iter;
        bit           tmo;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [31:0] m_data [2][4];
    int          m_iter [2];
    int          m_run  [2];
    bit          m_chg  [2];

    int n_vec = 0;
    int n_err = 0;

    function automatic bit relu_of(int d);   return (d == 0); endfunction
    function automatic int maxit_of(int d);  return (d == 0) ? 3 : 5; endfunction
    function automatic int stn_of(int d);    return (d == 0) ? 2 : 1; endfunction

    function automatic exp_t mk_exp(int d);
        exp_t e;
        e.nz = 0;
        for (int i = 0; i < 4; i++) begin
            e.data[i*32 +: 32] = m_data[d][i];
            if (m_data[d][i] != 32'd0) e.nz++;
        end
        e.win  = (e.nz == 1);
        e.chg  = m_chg[d];
        e.stb  = (m_run[d] == stn_of(d));
        e.iter = m_iter[d];
        e.tmo  = (m_iter[d] == maxit_of(d));
        return e;
    endfunction

    task automatic model_step(int d);
        logic [31:0] v;
        bit c;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_data[d][i] = 32'd0;
            m_iter[d] = 0; m_run[d] = 0; m_chg[d] = 1'b0;
        end else if (ldInit) begin
            for (int i = 0; i < 4; i++) m_data[d][i] = initDataIn[i*32 +: 32];
            m_iter[d] = 0; m_run[d] = 0; m_chg[d] = 1'b0;
        end else if (ldA) begin
            c = 1'b0;
            for (int i = 0; i < 4; i++) begin
                v = newDataIn[i*32 +: 32];
                if (relu_of(d) && v[31]) v = 32'd0;
                if (chEn[i]) begin
                    if (v != m_data[d][i]) c = 1'b1;
                    m_data[d][i] = v;
                end
            end
            m_chg[d] = c;
            if (c) m_run[d] = 0;
            else if (m_run[d] < stn_of(d)) m_run[d]++;
            if (m_iter[d] < maxit_of(d)) m_iter[d]++;
        end
    endtask

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cmp_set(string n, exp_t e, logic [127:0] dat, logic [2:0] nz,
                           logic w, logic c, logic s, logic [7:0] it, logic t);
        chk({n, ".dataOut"},    dat, e.data);
        chk({n, ".nonZeroCnt"}, 128'(nz), 128'(e.nz));
        chk({n, ".winner"},     128'(w), 128'(e.win));
        chk({n, ".changed"},    128'(c), 128'(e.chg));
        chk({n, ".stable"},     128'(s), 128'(e.stb));
        chk({n, ".iterCnt"},    128'(it), 128'(e.iter));
        chk({n, ".timeout"},    128'(t), 128'(e.tmo));
    endtask

    // One clock: drive, predict, push, let the edge happen, pop and compare.
    task automatic cyc(input bit r, input bit li, input bit la, input logic [3:0] en,
                       input logic [127:0] ini, input logic [127:0] nw, input string tag);
        exp_t ea, eb;
        rst = r; ldInit = li; ldA = la; chEn = en; initDataIn = ini; newDataIn = nw;
        model_step(0);
        model_step(1);
        q_a.push_back(mk_exp(0));
        q_b.push_back(mk_exp(1));
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        cmp_set({tag, "/A"}, ea, a_dataOut, a_nz, a_win, a_chg, a_stb, a_iter, a_tmo);
        cmp_set({tag, "/B"}, eb, b_dataOut, b_nz, b_win, b_chg, b_stb, b_iter, b_tmo);
    endtask

    localparam logic [127:0] INIT4321 = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] NEW_T2   = {32'd9, 32'd9, 32'hFFFF_FFFB, 32'd0};

    initial begin
        rst = 1'b1; ldInit = 1'b0; ldA = 1'b0; chEn = '0; initDataIn = '0; newDataIn = '0;
        #2;
        cyc(1, 0, 0, 4'h0, '0, '0, "reset0");
        cyc(1, 0, 0, 4'h0, '0, '0, "reset1");
        chk("reset.dataOut", a_dataOut, 128'd0);
        chk("reset.stable",  128'(a_stb), 128'd0);

        // Reset in the middle of an iteration discards everything.
        cyc(0, 1, 0, 4'h0, INIT4321, '0, "mr_init");
        cyc(0, 0, 1, 4'hF, {32'd5, 32'd6, 32'd7, 32'd8}, {32'd5, 32'd6, 32'd7, 32'd8}, "mr_upd1");
        cyc(0, 0, 1, 4'h3, '0, {32'd1, 32'd1, 32'd1, 32'd1}, "mr_upd2");
        cyc(0, 0, 1, 4'h5, '0, {32'd2, 32'd2, 32'd2, 32'd2}, "mr_upd3");
        cyc(1, 0, 1, 4'hF, INIT4321, INIT4321, "mr_rst");
        chk("mr.iterCnt",    128'(a_iter), 128'd0);
        chk("mr.nonZeroCnt", 128'(a_nz),   128'd0);

        // Masked update with clamp of a negative value.
        cyc(0, 1, 0, 4'h0, INIT4321, '0, "t2_init");
        cyc(0, 0, 1, 4'b0011, '0, NEW_T2, "t2_upd");
        chk("t2.dataOut",    a_dataOut, {32'd4, 32'd3, 32'd0, 32'd0});
        chk("t2.nonZeroCnt", 128'(a_nz),  128'd2);
        chk("t2.changed",    128'(a_chg), 128'd1);
        chk("t2.iterCnt",    128'(a_iter), 128'd1);

        // Identical updates build up stability.
        cyc(0, 0, 1, 4'b0011, '0, NEW_T2, "t3_rep1");
        chk("t3.rep1.changed", 128'(a_chg), 128'd0);
        chk("t3.rep1.stable",  128'(a_stb), 128'd0);
        cyc(0, 0, 1, 4'b0011, '0, NEW_T2, "t3_rep2");
        chk("t3.rep2.stable",  128'(a_stb),  128'd1);
        chk("t3.rep2.iterCnt", 128'(a_iter), 128'd3);

        // Changing update clears stable and leaves a single winner.
        cyc(0, 0, 1, 4'hF, '0, {32'd0, 32'd0, 32'd7, 32'd0}, "t4_win");
        chk("t4.stable",  128'(a_stb), 128'd0);
        chk("t4.winner",  128'(a_win), 128'd1);
        chk("t4.dataOut", a_dataOut, {32'd0, 32'd0, 32'd7, 32'd0});

        cyc(0, 0, 0, 4'hF, INIT4321, INIT4321, "idle");

        // Saturation of the iteration counter while data keeps moving.
        cyc(0, 1, 0, 4'h0, INIT4321, '0, "t5_init");
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 0, 1, 4'h1, '0, 128'(k * 11), "t5_upd");
            chk("t5.iterCnt", 128'(a_iter), 128'((k < 3) ? k : 3));
            chk("t5.timeout", 128'(a_tmo),  128'(k >= 3));
            chk("t5.data0",   128'(a_dataOut[31:0]), 128'(k * 11));
        end

        cyc(0, 0, 1, 4'h0, '0, {32'd1, 32'd2, 32'd3, 32'd4}, "noen");

        // ldInit wins over ldA; init values are stored raw.
        cyc(0, 1, 1, 4'hF, {32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd0}, INIT4321, "t6_both");
        chk("t6.iterCnt",    128'(b_iter), 128'd0);
        chk("t6.nonZeroCnt", 128'(b_nz),   128'd2);
        chk("t6.A.data3",    128'(a_dataOut[127:96]), 128'hFFFF_FFFF);

        cyc(0, 0, 1, 4'b1010, '0, {32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd0}, "t6_raw");
        chk("t6.raw.B.nz", 128'(b_nz), 128'd2);
        chk("t6.raw.A.nz", 128'(a_nz), 128'd0);

        // Mixed traffic from a small value set so repeats happen.
        for (int k = 0; k < 40; k++) begin
            logic [127:0] nv;
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0: nv[i*32 +: 32] = 32'd0;
                    1: nv[i*32 +: 32] = 32'd5;
                    2: nv[i*32 +: 32] = 32'hFFFF_FFF0;
                    default: nv[i*32 +: 32] = 32'h8000_0000;
                endcase
            end
            cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), nv, nv, "mix");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
